// File: rtl/adder_seq_nbit.sv
// adder_seq_nbit: multi-cycle WIDTH-bit add/sub, CHUNK bits per clock.
// Build option: define ADDER_SEQ_OVF_EN to build the signed-overflow flag.
module adder_seq_nbit #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   Sum,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [NCHUNK-1:0][CHUNK-1:0] a_q;
    logic [NCHUNK-1:0][CHUNK-1:0] b_q;
    logic [NCHUNK-1:0][CHUNK-1:0] partial;
    logic [NCHUNK-1:0][CHUNK-1:0] part_nxt;
    logic                         carry;
    logic [IW-1:0]                idx;
    logic [CHUNK:0]               csum;
    logic                         last;
    logic                         take;

    assign busy = (state == RUN);
    assign last = (idx == IW'(NCHUNK - 1));
    assign take = (state == IDLE) && start;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: leave RUN on the edge that handles the top chunk.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One chunk of the ripple add, merged into the partial result.
    always_comb begin
        csum = {1'b0, a_q[idx]} + {1'b0, b_q[idx]} + {{CHUNK{1'b0}}, carry};
        part_nxt = partial;
        part_nxt[idx] = csum[CHUNK-1:0];
    end

    // Operand capture, chunk iteration and result publication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            partial <= '0;
            carry   <= 1'b0;
            idx     <= '0;
            Sum     <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (take) begin
                a_q   <= A;
                b_q   <= B ^ {WIDTH{sub}};
                carry <= sub;
                idx   <= '0;
            end else if (state == RUN) begin
                partial <= part_nxt;
                carry   <= csum[CHUNK];
                if (last) begin
                    idx  <= '0;
                    Sum  <= {csum[CHUNK], part_nxt};
                    done <= 1'b1;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

`ifdef ADDER_SEQ_OVF_EN
    logic cin_msb;

    assign cin_msb = csum[CHUNK-1] ^ a_q[idx][CHUNK-1] ^ b_q[idx][CHUNK-1];

    // Signed overflow: carry into MSB differs from carry out of MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if ((state == RUN) && last) begin
            ovf <= cin_msb ^ csum[CHUNK];
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_adder_seq_nbit.sv
// tb_adder_seq_nbit: directed and random checks of adder_seq_nbit
// against an arithmetic reference model (WIDTH=8, CHUNK=4).
module tb_adder_seq_nbit;

    localparam int W = 8;
    localparam int C = 4;
    localparam int N = W / C;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W:0]   Sum;
    logic         ovf;

    int tests = 0;
    int fails = 0;

    logic [W:0] prev_sum = '0;
    logic       prev_ovf = 1'b0;

    adder_seq_nbit #(.WIDTH(W), .CHUNK(C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .Sum   (Sum),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W:0] m_sum(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic s);
        int unsigned ua;
        int unsigned ub;
        int unsigned d;
        ua = a;
        ub = b;
        if (!s) return (W+1)'(ua + ub);
        d = (ua - ub) % (1 << W);
        return {(ua >= ub), d[W-1:0]};
    endfunction

    function automatic logic m_ovf(input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   input logic s);
`ifdef ADDER_SEQ_OVF_EN
        int sa;
        int sb;
        int r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        r = s ? (sa - sb) : (sa + sb);
        return (r > 127) || (r < -128);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [W-1:0] a,
                         input logic [W-1:0] b,
                         input logic s);
        logic [W:0] es;
        logic       eo;
        es = m_sum(a, b, s);
        eo = m_ovf(a, b, s);
        A = a;
        B = b;
        sub = s;
        start = 1'b1;
        tick();
        for (int i = 0; i < N; i++) begin
            check("busy_run", 32'(busy), 32'd1);
            check("done_run", 32'(done), 32'd0);
            check("sum_hold", 32'(Sum), 32'(prev_sum));
            check("ovf_hold", 32'(ovf), 32'(prev_ovf));
            start = 1'($urandom);
            A = W'($urandom);
            B = W'($urandom);
            sub = 1'($urandom);
            tick();
        end
        start = 1'b0;
        check("done_end", 32'(done), 32'd1);
        check("busy_end", 32'(busy), 32'd0);
        check("sum", 32'(Sum), 32'(es));
        check("ovf", 32'(ovf), 32'(eo));
        prev_sum = es;
        prev_ovf = eo;
        tick();
        check("done_pulse", 32'(done), 32'd0);
        check("sum_keep", 32'(Sum), 32'(es));
    endtask

    task automatic b2b(input int count);
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W:0]   es;
        logic         eo;
        a = W'($urandom);
        b = W'($urandom);
        s = 1'($urandom);
        start = 1'b1;
        for (int k = 0; k < count; k++) begin
            A = a;
            B = b;
            sub = s;
            es = m_sum(a, b, s);
            eo = m_ovf(a, b, s);
            tick();
            for (int i = 0; i < N; i++) begin
                check("b2b_busy", 32'(busy), 32'd1);
                check("b2b_nodone", 32'(done), 32'd0);
                A = W'($urandom);
                B = W'($urandom);
                sub = 1'($urandom);
                tick();
            end
            check("b2b_done", 32'(done), 32'd1);
            check("b2b_idle", 32'(busy), 32'd0);
            check("b2b_sum", 32'(Sum), 32'(es));
            check("b2b_ovf", 32'(ovf), 32'(eo));
            prev_sum = es;
            prev_ovf = eo;
            a = W'($urandom);
            b = W'($urandom);
            s = 1'($urandom);
        end
        start = 1'b0;
        tick();
        check("b2b_stop", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        sub = 1'($urandom);
        A = W'($urandom);
        B = W'($urandom);
        tick();
        tick();
        check("rst_sum", 32'(Sum), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_done", 32'(done), 32'd0);
        end

        do_op(8'h0F, 8'h01, 1'b0);
        check("add_0f_01", 32'(Sum), 32'h010);
        do_op(8'hFF, 8'hFF, 1'b0);
        check("add_ff_ff", 32'(Sum), 32'h1FE);
        do_op(8'h07, 8'h05, 1'b1);
        check("sub_07_05", 32'(Sum), 32'h102);
        do_op(8'h05, 8'h07, 1'b1);
        check("sub_05_07", 32'(Sum), 32'h0FE);
        do_op(8'h00, 8'h00, 1'b1);
        check("sub_eq", 32'(Sum), 32'h100);

        b2b(6);

        A = 8'h12;
        B = 8'h34;
        sub = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("abort_busy0", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(Sum), 32'd0);
        check("abort_ovf", 32'(ovf), 32'd0);
        prev_sum = '0;
        prev_ovf = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_nodone", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        tick();
        check("abort_idle", 32'(busy), 32'd0);
        do_op(8'h12, 8'h34, 1'b0);
        check("after_abort", 32'(Sum), 32'h046);

        do_op(8'h7F, 8'h01, 1'b0);
        check("ovf_add_sum", 32'(Sum), 32'h080);
        do_op(8'h80, 8'h01, 1'b1);
        check("ovf_sub_sum", 32'(Sum), 32'h17F);
        do_op(8'h10, 8'h20, 1'b0);
        check("noovf", 32'(ovf), 32'd0);

        for (int k = 0; k < 30; k++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom));
        end

        b2b(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
